// File: rtl/gol_display_pkg.sv
// Shared types and constants for the generation display/entry blocks:
// edit FSM encoding, BCD digit geometry and small BCD helpers.
package gol_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EDIT    = 2'd1,
    ST_CONVERT = 2'd2
  } fsm_state_t;

  localparam int DIGIT_W     = 4;
  localparam int NUM_DIGITS  = 4;
  localparam int CURSOR_W    = 2;
  localparam int MAX_DECIMAL = 9999;
  localparam int ACC_W       = 14;
  localparam int VALUE_W     = 16;
  localparam int NUM_BTNS    = 5;

  // Button indices, ordered so a higher index wins when presses coincide.
  localparam int BTN_RIGHT  = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_UP     = 3;
  localparam int BTN_CENTER = 4;

  function automatic logic [DIGIT_W-1:0] bcd_inc(input logic [DIGIT_W-1:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [DIGIT_W-1:0] bcd_dec(input logic [DIGIT_W-1:0] d);
    return (d == 4'd0 || d > 4'd9) ? 4'd9 : d - 4'd1;
  endfunction

  // acc*10 + d using shifts; acc never exceeds MAX_DECIMAL so 14 bits suffice.
  function automatic logic [ACC_W-1:0] mul10_add(input logic [ACC_W-1:0] acc,
                                                 input logic [DIGIT_W-1:0] d);
    return (acc << 3) + (acc << 1) + {{(ACC_W-DIGIT_W){1'b0}}, d};
  endfunction

endpackage

// File: rtl/generation_entry_if.sv
// Button inputs and edit/commit outputs of generation_entry. value_valid is a
// one-cycle strobe with no ready: the consumer must take value_out that cycle.
interface generation_entry_if;
  import gol_display_pkg::*;

  logic                          btn_up;
  logic                          btn_down;
  logic                          btn_left;
  logic                          btn_right;
  logic                          btn_center;
  logic [DIGIT_W*NUM_DIGITS-1:0] digits;
  logic [CURSOR_W-1:0]           cursor;
  logic                          editing;
  logic [VALUE_W-1:0]            value_out;
  logic                          value_valid;
  fsm_state_t                    state;
  logic [NUM_BTNS-1:0]           btn_level;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_center,
    input  digits, cursor, editing, value_out, value_valid, state, btn_level
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_center,
    output digits, cursor, editing, value_out, value_valid, state, btn_level
  );
endinterface

// File: rtl/button_debouncer.sv
// One pushbutton: 2-flop synchroniser, hold-time debounce and a registered
// one-cycle pulse on each debounced 0->1 transition.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DB_CNT_W        = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press_pulse,
  output logic level
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]          r_sync;
  logic                r_level;
  logic                r_press;
  logic [DB_CNT_W-1:0] r_cnt;

  // The counter only advances while the synced input disagrees with the
  // debounced level; any agreement restarts the hold window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= 2'b00;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], btn_raw};
      r_press <= 1'b0;
      if (r_sync[1] != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= ~r_level;
          r_press <= ~r_level;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign press_pulse = r_press;
  assign level       = r_level;

endmodule

// File: rtl/generation_entry.sv
// Pushbutton entry of a 4-digit BCD value with commit-time BCD->binary
// conversion and a one-cycle value_valid strobe.
module generation_entry
  import gol_display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DB_CNT_W        = 20
) (
  input logic              clk,
  input logic              rst,
  generation_entry_if.slave bus
);

  logic [NUM_BTNS-1:0] w_raw;
  logic [NUM_BTNS-1:0] w_press;
  logic [NUM_BTNS-1:0] w_level;
  logic [NUM_BTNS-1:0] w_act;

  assign w_raw[BTN_RIGHT]  = bus.btn_right;
  assign w_raw[BTN_LEFT]   = bus.btn_left;
  assign w_raw[BTN_DOWN]   = bus.btn_down;
  assign w_raw[BTN_UP]     = bus.btn_up;
  assign w_raw[BTN_CENTER] = bus.btn_center;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DB_CNT_W       (DB_CNT_W)
    ) u_db (
      .clk        (clk),
      .rst        (rst),
      .btn_raw    (w_raw[g]),
      .press_pulse(w_press[g]),
      .level      (w_level[g])
    );
  end

  // One-hot select of the highest-priority press; the rest are dropped.
  always_comb begin
    w_act = '0;
    if      (w_press[BTN_CENTER]) w_act[BTN_CENTER] = 1'b1;
    else if (w_press[BTN_UP])     w_act[BTN_UP]     = 1'b1;
    else if (w_press[BTN_DOWN])   w_act[BTN_DOWN]   = 1'b1;
    else if (w_press[BTN_LEFT])   w_act[BTN_LEFT]   = 1'b1;
    else if (w_press[BTN_RIGHT])  w_act[BTN_RIGHT]  = 1'b1;
  end

  fsm_state_t                          r_state;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] r_digits;
  logic [CURSOR_W-1:0]                 r_cursor;
  logic                                r_editing;
  logic [VALUE_W-1:0]                  r_value;
  logic                                r_valid;
  logic [ACC_W-1:0]                    r_acc;
  logic [1:0]                          r_step;
  logic [ACC_W-1:0]                    w_acc_next;

  // Most significant digit first: step 0 consumes d3, step 3 consumes d0.
  assign w_acc_next = mul10_add(r_acc, r_digits[2'd3 - r_step]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_digits  <= '0;
      r_cursor  <= 2'd3;
      r_editing <= 1'b0;
      r_value   <= '0;
      r_valid   <= 1'b0;
      r_acc     <= '0;
      r_step    <= 2'd0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_act[BTN_CENTER]) begin
            r_state   <= ST_EDIT;
            r_cursor  <= 2'd3;
            r_editing <= 1'b1;
          end
        end
        ST_EDIT: begin
          if (w_act[BTN_CENTER]) begin
            r_state   <= ST_CONVERT;
            r_editing <= 1'b0;
            r_acc     <= '0;
            r_step    <= 2'd0;
          end else if (w_act[BTN_UP]) begin
            r_digits[r_cursor] <= bcd_inc(r_digits[r_cursor]);
          end else if (w_act[BTN_DOWN]) begin
            r_digits[r_cursor] <= bcd_dec(r_digits[r_cursor]);
          end else if (w_act[BTN_LEFT]) begin
            r_cursor <= r_cursor + 2'd1;
          end else if (w_act[BTN_RIGHT]) begin
            r_cursor <= r_cursor - 2'd1;
          end
        end
        ST_CONVERT: begin
          r_acc  <= w_acc_next;
          r_step <= r_step + 2'd1;
          if (r_step == 2'd3) begin
            r_value <= {2'b00, w_acc_next};
            r_valid <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_editing <= 1'b0;
        end
      endcase
    end
  end

  assign bus.digits      = r_digits;
  assign bus.cursor      = r_cursor;
  assign bus.editing     = r_editing;
  assign bus.value_out   = r_value;
  assign bus.value_valid = r_valid;
  assign bus.state       = r_state;
  assign bus.btn_level   = w_level;

endmodule
